// File: rtl/root_drv_pkg.sv
// Shared types and defaults for the root driver: FSM state encoding,
// default widths/timeout, and the all-ones result reported on a timeout.
package root_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_W         = 16;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_TO_CYCLES = 1024;

    // Wide enough for any practical W; sliced down to W at the use site.
    localparam int                   ERR_MAX_W  = 64;
    localparam logic [ERR_MAX_W-1:0] ERR_RESULT = '1;

endpackage

// File: rtl/root_drv_edge.sv
// RD rise detector; rd_q resets high so an RD already high at reset release is not a rise.
// Latency: combinational rise flag from RD against last cycle's sample; no backpressure.
module root_drv_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rd_i,
    output logic rd_rise_o
);

    logic rd_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_q <= 1'b1;
        end else begin
            rd_q <= rd_i;
        end
    end

    assign rd_rise_o = rd_i & ~rd_q;

endmodule

// File: rtl/root_driver.sv
// Feeds operand pairs to a compute root (ST/RD handshake), returns one result per op.
// Latency: accept->ST 1 clk, RD rise->OUT_VALID 1 clk; IN_READY low until result is taken.
// Optional WAIT timeout with ERR output when ROOT_DRV_TIMEOUT_EN is defined.
module root_driver
    import root_drv_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TO_CYCLES = DEF_TO_CYCLES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [W-1:0]     A_IN,
    input  logic [W-1:0]     B_IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             ST,
    output logic [W-1:0]     IN0,
    output logic [W-1:0]     IN1,
    input  logic             RD,
    input  logic [W-1:0]     RES,
    output logic [W-1:0]     OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             BUSY,
    output logic [CNT_W-1:0] OP_CNT
`ifdef ROOT_DRV_TIMEOUT_EN
    ,
    output logic             ERR
`endif
);

    if (TO_CYCLES < 2) begin : g_to_cycles_chk
        $error("root_driver: TO_CYCLES must be at least 2");
    end

    state_t           state_q, state_d;
    logic [W-1:0]     in0_q, in0_d;
    logic [W-1:0]     in1_q, in1_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic             rd_rise;
    logic             timeout;
    logic             done;

    root_drv_edge u_edge (
        .clk_i     (CLK),
        .rst_n_i   (RST),
        .rd_i      (RD),
        .rd_rise_o (rd_rise)
    );

    assign done = (state_q == WAIT) && rd_rise;

`ifdef ROOT_DRV_TIMEOUT_EN
    if (W > ERR_MAX_W) begin : g_err_w_chk
        $error("root_driver: W exceeds ERR_MAX_W");
    end

    localparam int TO_W = $clog2(TO_CYCLES);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;

    assign timeout = (state_q == WAIT) && (to_cnt_q == TO_W'(TO_CYCLES - 1));

    // A coincident RD rise takes priority over the timeout result.
    always_comb begin
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (state_q == START) begin
            to_cnt_d = '0;
        end else if (state_q == WAIT) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        if (timeout && !rd_rise) begin
            err_d = 1'b1;
        end else if ((state_q == HOLD) && OUT_READY) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (IN_VALID) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (rd_rise || timeout) state_d = HOLD;
            HOLD:    if (OUT_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs come only from the state register.
    always_comb begin
        IN_READY  = (state_q == IDLE);
        ST        = (state_q == START);
        OUT_VALID = (state_q == HOLD);
        BUSY      = (state_q != IDLE);
    end

    always_comb begin
        in0_d      = in0_q;
        in1_d      = in1_q;
        out_data_d = out_data_q;
        op_cnt_d   = op_cnt_q;
        if ((state_q == IDLE) && IN_VALID) begin
            in0_d = A_IN;
            in1_d = B_IN;
        end
        if (done) begin
            out_data_d = RES;
            op_cnt_d   = op_cnt_q + CNT_W'(1);
        end
`ifdef ROOT_DRV_TIMEOUT_EN
        else if (timeout) begin
            out_data_d = ERR_RESULT[W-1:0];
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            in0_q      <= '0;
            in1_q      <= '0;
            out_data_q <= '0;
            op_cnt_q   <= '0;
        end else begin
            in0_q      <= in0_d;
            in1_q      <= in1_d;
            out_data_q <= out_data_d;
            op_cnt_q   <= op_cnt_d;
        end
    end

    assign IN0      = in0_q;
    assign IN1      = in1_q;
    assign OUT_DATA = out_data_q;
    assign OP_CNT   = op_cnt_q;

endmodule

// File: tb/tb_root_driver.sv
// Bench for root_driver: the root is modelled as an adder whose RD timing each scenario controls.
module tb_root_driver;

    localparam int W         = 16;
    localparam int CNT_W     = 4;
    localparam int TO_CYCLES = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic [W-1:0]     A_IN, B_IN, RES;
    logic             IN_VALID, RD, OUT_READY;
    logic             IN_READY, ST, OUT_VALID, BUSY;
    logic [W-1:0]     IN0, IN1, OUT_DATA;
    logic [CNT_W-1:0] OP_CNT;
`ifdef ROOT_DRV_TIMEOUT_EN
    logic             ERR;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    root_driver #(.W(W), .CNT_W(CNT_W), .TO_CYCLES(TO_CYCLES)) dut (
        .CLK(CLK), .RST(RST), .A_IN(A_IN), .B_IN(B_IN), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .ST(ST), .IN0(IN0), .IN1(IN1), .RD(RD), .RES(RES),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .BUSY(BUSY), .OP_CNT(OP_CNT)
`ifdef ROOT_DRV_TIMEOUT_EN
        , .ERR(ERR)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [CNT_W-1:0] cnt_mod(input int n);
        return CNT_W'(n % (1 << CNT_W));
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; A_IN = '0; B_IN = '0; IN_VALID = 1'b0; RD = 1'b0; RES = '0; OUT_READY = 1'b0;
        #12;
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
        n_checks++; if (ST !== 1'b0) begin n_fail++; $display("FAIL reset_st: got %b want 0", ST); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
        n_checks++; if (OP_CNT !== '0) begin n_fail++; $display("FAIL reset_op_cnt: got %h want 0", OP_CNT); end
        n_checks++; if ({IN0, IN1, OUT_DATA} !== '0) begin n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", IN0, IN1, OUT_DATA); end
`ifdef ROOT_DRV_TIMEOUT_EN
        n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", ERR); end
`endif
        tick();
        RST = 1'b1;
        exp_cnt = 0;
        tick();
    endtask

    task automatic test_basic();
        IN_VALID = 1'b1; A_IN = 16'h0003; B_IN = 16'h0004;
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL basic_ready_c0: got %b want 1", IN_READY); end
        tick();
        n_checks++; if (ST !== 1'b1) begin n_fail++; $display("FAIL basic_st_c1: got %b want 1", ST); end
        n_checks++; if ({IN0, IN1} !== {16'h0003, 16'h0004}) begin n_fail++; $display("FAIL basic_operands: got %h/%h want 0003/0004", IN0, IN1); end
        n_checks++; if (IN_READY !== 1'b0 || BUSY !== 1'b1) begin n_fail++; $display("FAIL basic_busy_c1: got ready=%b busy=%b want 0/1", IN_READY, BUSY); end
        IN_VALID = 1'b0; A_IN = 16'hDEAD; B_IN = 16'hBEEF;
        tick();
        n_checks++; if (ST !== 1'b0) begin n_fail++; $display("FAIL basic_st_c2: got %b want 0", ST); end
        tick();
        tick();
        RD = 1'b1; RES = 16'h0007;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid_c4: got %b want 0", OUT_VALID); end
        tick();
        exp_cnt++;
        n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'h0007) begin n_fail++; $display("FAIL basic_result_c5: got v=%b d=%h want 1/0007", OUT_VALID, OUT_DATA); end
        n_checks++; if (OP_CNT !== cnt_mod(exp_cnt)) begin n_fail++; $display("FAIL basic_op_cnt: got %0d want %0d", OP_CNT, cnt_mod(exp_cnt)); end
        n_checks++; if (IN0 !== 16'h0003) begin n_fail++; $display("FAIL basic_in0_hold: got %h want 0003", IN0); end
        RD = 1'b0; OUT_READY = 1'b1;
        tick();
        n_checks++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin n_fail++; $display("FAIL basic_return_idle: got v=%b r=%b want 0/1", OUT_VALID, IN_READY); end
        OUT_READY = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a1, b1, a2, b2, r1, r2;
        a1 = W'($urandom); b1 = W'($urandom); a2 = W'($urandom); b2 = W'($urandom);
        r1 = a1 + b1; r2 = a2 + b2;
        IN_VALID = 1'b1; A_IN = a1; B_IN = b1;
        tick();
        A_IN = a2; B_IN = b2;
        tick();
        RD = 1'b1; RES = r1;
        tick();
        exp_cnt++;
        RD = 1'b0; RES = W'($urandom);
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== r1) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want 1/%h", i, OUT_VALID, OUT_DATA, r1); end
            n_checks++; if (IN_READY !== 1'b0 || ST !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept[%0d]: got ready=%b st=%b want 0/0", i, IN_READY, ST); end
            n_checks++; if (IN0 !== a1 || IN1 !== b1) begin n_fail++; $display("FAIL bp_operands[%0d]: got %h/%h want %h/%h", i, IN0, IN1, a1, b1); end
            tick();
        end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        n_checks++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || ST !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got r=%b v=%b st=%b want 1/0/0", IN_READY, OUT_VALID, ST); end
        tick();
        IN_VALID = 1'b0;
        n_checks++; if (ST !== 1'b1 || IN0 !== a2 || IN1 !== b2) begin n_fail++; $display("FAIL bp_second_accept: got st=%b %h/%h want 1 %h/%h", ST, IN0, IN1, a2, b2); end
        tick();
        RD = 1'b1; RES = r2;
        tick();
        exp_cnt++;
        n_checks++; if (OUT_DATA !== r2 || OP_CNT !== cnt_mod(exp_cnt)) begin n_fail++; $display("FAIL bp_second_result: got %h cnt=%0d want %h cnt=%0d", OUT_DATA, OP_CNT, r2, cnt_mod(exp_cnt)); end
        RD = 1'b0; OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    task automatic test_stale_rd();
        RST = 1'b0; RD = 1'b1; RES = 16'h0055;
        #10;
        RST = 1'b1;
        exp_cnt = 0;
        tick();
        IN_VALID = 1'b1; A_IN = 16'h0050; B_IN = 16'h005A;
        tick();
        IN_VALID = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            tick();
            if (c == 4) RD = 1'b0;
            if (c == 6) begin RD = 1'b1; RES = 16'h00AA; end
            n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL stale_early_capture_c%0d: got %b want 0", c, OUT_VALID); end
        end
        tick();
        exp_cnt++;
        n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'h00AA) begin n_fail++; $display("FAIL stale_result_c7: got v=%b d=%h want 1/00aa", OUT_VALID, OUT_DATA); end
        n_checks++; if (OP_CNT !== cnt_mod(exp_cnt)) begin n_fail++; $display("FAIL stale_op_cnt: got %0d want %0d", OP_CNT, cnt_mod(exp_cnt)); end
        RD = 1'b0; OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        IN_VALID = 1'b1; A_IN = 16'h1234; B_IN = 16'h4321;
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        #1;
        exp_cnt = 0;
        n_checks++; if (BUSY !== 1'b0 || ST !== 1'b0 || OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin n_fail++; $display("FAIL midrst_ctrl: got busy=%b st=%b v=%b r=%b want 0/0/0/1", BUSY, ST, OUT_VALID, IN_READY); end
        n_checks++; if ({IN0, IN1, OUT_DATA} !== '0 || OP_CNT !== '0) begin n_fail++; $display("FAIL midrst_data: got %h/%h/%h cnt=%0d want 0", IN0, IN1, OUT_DATA, OP_CNT); end
        #3;
        RST = 1'b1;
        tick();
        RD = 1'b1; RES = 16'h5555;
        tick();
        RD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (OUT_VALID !== 1'b0 || ST !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet[%0d]: got v=%b st=%b busy=%b want 0/0/0", i, OUT_VALID, ST, BUSY); end
        end
    endtask

    task automatic test_random_wrap();
        logic [W-1:0] a, b, r;
        int d;
        for (int op = 1; op <= 17; op++) begin
            repeat ($urandom_range(2, 0)) tick();
            a = W'($urandom); b = W'($urandom); r = a + b;
            IN_VALID = 1'b1; A_IN = a; B_IN = b;
            n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want 1", op, IN_READY); end
            tick();
            IN_VALID = 1'b0;
            n_checks++; if (ST !== 1'b1 || IN0 !== a || IN1 !== b) begin n_fail++; $display("FAIL rnd_start[%0d]: got st=%b %h/%h want 1 %h/%h", op, ST, IN0, IN1, a, b); end
            tick();
            d = $urandom_range(3, 0);
            for (int i = 0; i < d; i++) begin
                n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rnd_early[%0d]: got %b want 0", op, OUT_VALID); end
                tick();
            end
            RD = 1'b1; RES = r;
            tick();
            exp_cnt++;
            RD = 1'b0;
            n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== r) begin n_fail++; $display("FAIL rnd_result[%0d]: got v=%b d=%h want 1/%h", op, OUT_VALID, OUT_DATA, r); end
            n_checks++; if (OP_CNT !== cnt_mod(exp_cnt)) begin n_fail++; $display("FAIL rnd_op_cnt[%0d]: got %0d want %0d", op, OP_CNT, cnt_mod(exp_cnt)); end
            repeat ($urandom_range(2, 0)) tick();
            OUT_READY = 1'b1;
            tick();
            OUT_READY = 1'b0;
            n_checks++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin n_fail++; $display("FAIL rnd_release[%0d]: got v=%b r=%b want 0/1", op, OUT_VALID, IN_READY); end
        end
        n_checks++; if (OP_CNT !== 4'd1) begin n_fail++; $display("FAIL wrap_after_17: got %0d want 1", OP_CNT); end
    endtask

`ifdef ROOT_DRV_TIMEOUT_EN
    task automatic test_timeout();
        logic [W-1:0] r;
        IN_VALID = 1'b1; A_IN = 16'h0BAD; B_IN = 16'h0001;
        tick();
        IN_VALID = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            tick();
            n_checks++; if (OUT_VALID !== 1'b0 || IN0 !== 16'h0BAD) begin n_fail++; $display("FAIL to_wait_c%0d: got v=%b in0=%h want 0/0bad", c, OUT_VALID, IN0); end
        end
        tick();
        n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'hFFFF || ERR !== 1'b1) begin n_fail++; $display("FAIL to_result: got v=%b d=%h err=%b want 1/ffff/1", OUT_VALID, OUT_DATA, ERR); end
        n_checks++; if (OP_CNT !== cnt_mod(exp_cnt)) begin n_fail++; $display("FAIL to_op_cnt: got %0d want %0d", OP_CNT, cnt_mod(exp_cnt)); end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        n_checks++; if (ERR !== 1'b0 || OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got err=%b v=%b want 0/0", ERR, OUT_VALID); end
        r = W'($urandom);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        repeat (7) tick();
        RD = 1'b1; RES = r;
        tick();
        exp_cnt++;
        RD = 1'b0;
        n_checks++; if (OUT_DATA !== r || ERR !== 1'b0 || OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL to_coincide: got d=%h err=%b v=%b want %h/0/1", OUT_DATA, ERR, OUT_VALID, r); end
        n_checks++; if (OP_CNT !== cnt_mod(exp_cnt)) begin n_fail++; $display("FAIL to_coincide_cnt: got %0d want %0d", OP_CNT, cnt_mod(exp_cnt)); end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask
`else
    task automatic test_unbounded_wait();
        IN_VALID = 1'b1; A_IN = 16'h0100; B_IN = 16'h0200;
        tick();
        IN_VALID = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_checks++; if (OUT_VALID !== 1'b0 || BUSY !== 1'b1) begin n_fail++; $display("FAIL long_wait[%0d]: got v=%b busy=%b want 0/1", i, OUT_VALID, BUSY); end
        end
        RD = 1'b1; RES = 16'h0300;
        tick();
        exp_cnt++;
        RD = 1'b0;
        n_checks++; if (OUT_DATA !== 16'h0300 || OP_CNT !== cnt_mod(exp_cnt)) begin n_fail++; $display("FAIL long_wait_result: got %h cnt=%0d want 0300 cnt=%0d", OUT_DATA, OP_CNT, cnt_mod(exp_cnt)); end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stale_rd();
        test_reset_mid_wait();
        test_random_wrap();
`ifdef ROOT_DRV_TIMEOUT_EN
        test_timeout();
`else
        test_unbounded_wait();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
